// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the 6-digit multiplexed 7-segment display scanner.
//   - Active-low 7-bit glyph patterns, bit order {g,f,e,d,c,b,a}
//   - Idle bus values SEG_OFF / SEL_OFF and the digit count
//   - Blink state encoding
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [5:0] SEL_OFF = 6'h3F;

    // Active-low glyphs {g,f,e,d,c,b,a}; a cleared bit lights that segment.
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic {
        ST_ON  = 1'b0,
        ST_OFF = 1'b1
    } blink_state_e;

endpackage

// File: rtl/seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Combinational nibble + decimal point -> active-low segment pattern.
//   nibble  in  4  digit value; 0-9 glyph, 15 dash, 10-14 blank
//   dp      in  1  decimal point, 1 = lit
//   pattern out 8  {dp,g,f,e,d,c,b,a}, active low
// -----------------------------------------------------------------------------
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    logic [6:0] glyph_s;

    // Nibble to glyph lookup.
    always_comb begin
        glyph_s = GLYPH_BLANK;
        case (nibble)
            4'd0:    glyph_s = GLYPH_0;
            4'd1:    glyph_s = GLYPH_1;
            4'd2:    glyph_s = GLYPH_2;
            4'd3:    glyph_s = GLYPH_3;
            4'd4:    glyph_s = GLYPH_4;
            4'd5:    glyph_s = GLYPH_5;
            4'd6:    glyph_s = GLYPH_6;
            4'd7:    glyph_s = GLYPH_7;
            4'd8:    glyph_s = GLYPH_8;
            4'd9:    glyph_s = GLYPH_9;
            4'd15:   glyph_s = GLYPH_DASH;
            default: glyph_s = GLYPH_BLANK;
        endcase
    end

    assign pattern = {~dp, glyph_s};

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan scheduler for a shared 6-digit 7-segment bus.
// One digit owns the bus per slot; digit data is snapshotted once per frame;
// the bus is blanked for BLANK_CYC clocks at each slot start; set-mode blink
// blanks the digits whose blink_sel bit is 0 during the blink off-phase.
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active high
//   bcd_in       in   24  digit nibbles, [3:0] = digit 0 (rightmost)
//   dp_in        in   6   decimal point per digit, 1 = lit
//   set_en       in   1   set mode, enables blinking
//   blink_sel    in   6   per-digit blink select, 0 = digit blinks
//   dim_level    in   3   brightness 0..7 (only with SEG_DIM_EN)
//   seg          out  8   {dp,g,f,e,d,c,b,a}, active low
//   sel          out  6   digit enable, one-hot active low
//   blink_phase  out  1   1 = blink on-phase
//   frame_tick   out  1   pulse when a new frame snapshot is taken
// Build option: define SEG_DIM_EN to add dim_level PWM dimming.
// After reset one priming slot runs with the bus blank; its slot_tick takes
// the first snapshot so real data is shown from the first digit-0 slot.
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int SCAN_HZ         = 1_000,
    parameter int BLANK_CYC       = 4,
    parameter int BLINK_ON_TICKS  = 400,
    parameter int BLINK_OFF_TICKS = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bcd_in,
    input  logic [5:0]  dp_in,
    input  logic        set_en,
    input  logic [5:0]  blink_sel,
`ifdef SEG_DIM_EN
    input  logic [2:0]  dim_level,
`endif
    output logic [7:0]  seg,
    output logic [5:0]  sel,
    output logic        blink_phase,
    output logic        frame_tick
);

    localparam int DIV    = CLK_HZ / SCAN_HZ;
    localparam int PCNT_W = $clog2(DIV);
    localparam int BMAX   = (BLINK_ON_TICKS > BLINK_OFF_TICKS) ? BLINK_ON_TICKS : BLINK_OFF_TICKS;
    localparam int CNT_W  = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(DIV - 1);
    localparam logic [PCNT_W-1:0] PCNT_BLNK = PCNT_W'(BLANK_CYC);
    localparam logic [2:0]        IDX_MAX   = 3'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(BLINK_ON_TICKS - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(BLINK_OFF_TICKS - 1);

    logic [PCNT_W-1:0] pcnt_r;
    logic [2:0]        idx_r;
    logic              run_r;
    logic [23:0]       bcd_sh_r;
    logic [5:0]        dp_sh_r;
    logic              set_en_d_r;
    blink_state_e      state_r, state_nx_s;
    logic [CNT_W-1:0]  bcnt_r, bcnt_nx_s;
    logic [7:0]        seg_r, seg_nx_s;
    logic [5:0]        sel_r, sel_nx_s;
    logic              blink_phase_r, frame_tick_r;

    logic              slot_tick_s, wrap_s;
    logic [3:0]        cur_nib_s;
    logic              cur_dp_s, cur_bsel_s;
    logic [7:0]        pattern_s;
    logic              blink_blank_s, dim_blank_s;

    assign slot_tick_s = (pcnt_r == PCNT_MAX);
    // Priming slot counts as a wrap so the first snapshot happens right away.
    assign wrap_s      = slot_tick_s & (~run_r | (idx_r == IDX_MAX));

    // Prescaler, digit index, priming flag and frame snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r     <= '0;
            idx_r      <= 3'd0;
            run_r      <= 1'b0;
            bcd_sh_r   <= 24'h000000;
            dp_sh_r    <= 6'h00;
            set_en_d_r <= 1'b0;
        end else begin
            set_en_d_r <= set_en;
            if (slot_tick_s) begin
                pcnt_r <= '0;
                run_r  <= 1'b1;
                if (wrap_s) begin
                    idx_r    <= 3'd0;
                    bcd_sh_r <= bcd_in;
                    dp_sh_r  <= dp_in;
                end else begin
                    idx_r <= idx_r + 3'd1;
                end
            end else begin
                pcnt_r <= pcnt_r + PCNT_W'(1);
            end
        end
    end

    // Current digit's shadow nibble, dp and live blink select.
    always_comb begin
        cur_nib_s  = 4'hA;
        cur_dp_s   = 1'b0;
        cur_bsel_s = 1'b1;
        case (idx_r)
            3'd0:    begin cur_nib_s = bcd_sh_r[3:0];   cur_dp_s = dp_sh_r[0]; cur_bsel_s = blink_sel[0]; end
            3'd1:    begin cur_nib_s = bcd_sh_r[7:4];   cur_dp_s = dp_sh_r[1]; cur_bsel_s = blink_sel[1]; end
            3'd2:    begin cur_nib_s = bcd_sh_r[11:8];  cur_dp_s = dp_sh_r[2]; cur_bsel_s = blink_sel[2]; end
            3'd3:    begin cur_nib_s = bcd_sh_r[15:12]; cur_dp_s = dp_sh_r[3]; cur_bsel_s = blink_sel[3]; end
            3'd4:    begin cur_nib_s = bcd_sh_r[19:16]; cur_dp_s = dp_sh_r[4]; cur_bsel_s = blink_sel[4]; end
            3'd5:    begin cur_nib_s = bcd_sh_r[23:20]; cur_dp_s = dp_sh_r[5]; cur_bsel_s = blink_sel[5]; end
            default: begin cur_nib_s = 4'hA;            cur_dp_s = 1'b0;       cur_bsel_s = 1'b1;         end
        endcase
    end

    seg_decode u_decode (
        .nibble  (cur_nib_s),
        .dp      (cur_dp_s),
        .pattern (pattern_s)
    );

`ifdef SEG_DIM_EN
    localparam int              DW      = PCNT_W + 4;
    localparam logic [DW-1:0]   WIN_LEN = DW'(DIV - BLANK_CYC);

    logic [2:0]    dim_sh_r;
    logic [DW-1:0] dim_pos_s, dim_lim_s;

    // Brightness is taken together with the frame snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            dim_sh_r <= 3'd0;
        end else if (wrap_s) begin
            dim_sh_r <= dim_level;
        end else begin
            dim_sh_r <= dim_sh_r;
        end
    end

    // Sub-window (pos*8/len) <= level  <=>  pos*8 < (level+1)*len.
    assign dim_pos_s   = DW'(pcnt_r - PCNT_BLNK) << 3;
    assign dim_lim_s   = DW'({1'b0, dim_sh_r} + 4'd1) * WIN_LEN;
    assign dim_blank_s = (dim_pos_s >= dim_lim_s);
`else
    assign dim_blank_s = 1'b0;
`endif

    // Blink FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ON;
            bcnt_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            bcnt_r  <= bcnt_nx_s;
        end
    end

    // Blink FSM next state; a set_en rising edge restarts ahead of any tick.
    always_comb begin
        state_nx_s = state_r;
        bcnt_nx_s  = bcnt_r;
        if (!set_en || !set_en_d_r) begin
            state_nx_s = ST_ON;
            bcnt_nx_s  = '0;
        end else if (slot_tick_s) begin
            case (state_r)
                ST_ON: begin
                    if (bcnt_r == ON_LAST) begin
                        state_nx_s = ST_OFF;
                        bcnt_nx_s  = '0;
                    end else begin
                        bcnt_nx_s  = bcnt_r + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (bcnt_r == OFF_LAST) begin
                        state_nx_s = ST_ON;
                        bcnt_nx_s  = '0;
                    end else begin
                        bcnt_nx_s  = bcnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s = ST_ON;
                    bcnt_nx_s  = '0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
            bcnt_nx_s  = bcnt_r;
        end
    end

    // Blink FSM outputs and next bus values.
    always_comb begin
        blink_blank_s = set_en & (state_r == ST_OFF) & ~cur_bsel_s;
        seg_nx_s      = SEG_OFF;
        sel_nx_s      = SEL_OFF;
        if (!run_r || (pcnt_r < PCNT_BLNK)) begin
            seg_nx_s = SEG_OFF;
            sel_nx_s = SEL_OFF;
        end else begin
            sel_nx_s = ~(6'd1 << idx_r);
            if (blink_blank_s || dim_blank_s) begin
                seg_nx_s = SEG_OFF;
            end else begin
                seg_nx_s = pattern_s;
            end
        end
    end

    // Output registers; blink_phase follows the FSM state it is updated with.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r         <= SEG_OFF;
            sel_r         <= SEL_OFF;
            blink_phase_r <= 1'b1;
            frame_tick_r  <= 1'b0;
        end else begin
            seg_r         <= seg_nx_s;
            sel_r         <= sel_nx_s;
            blink_phase_r <= (state_nx_s == ST_ON);
            frame_tick_r  <= wrap_s;
        end
    end

    assign seg         = seg_r;
    assign sel         = sel_r;
    assign blink_phase = blink_phase_r;
    assign frame_tick  = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed + randomized bench for seg_scan_ctrl (DIV=10, BLANK_CYC=2, blink 4/2).
// The reference model works from absolute time since reset: slot number,
// position in slot, and a count of blink ticks since set mode was entered.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int B_ON  = 4;
    localparam int B_OFF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] bcd_in = 24'h000000;
    logic [5:0]  dp_in = 6'h00;
    logic        set_en = 1'b0;
    logic [5:0]  blink_sel = 6'h3F;
`ifdef SEG_DIM_EN
    logic [2:0]  dim_level = 3'd7;
`endif
    logic [7:0]  seg;
    logic [5:0]  sel;
    logic        blink_phase;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;

    // model state
    int          n = 0;
    int          k = 0;
    bit          sp = 1'b0;
    logic [23:0] sh_bcd = 24'h000000;
    logic [5:0]  sh_dp = 6'h00;
    int          sh_dim = 0;
    logic [6:0]  glyph_hi [16];

    seg_scan_ctrl #(
        .CLK_HZ          (1000),
        .SCAN_HZ         (100),
        .BLANK_CYC       (BLANK),
        .BLINK_ON_TICKS  (B_ON),
        .BLINK_OFF_TICKS (B_OFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .set_en      (set_en),
        .blink_sel   (blink_sel),
`ifdef SEG_DIM_EN
        .dim_level   (dim_level),
`endif
        .seg         (seg),
        .sel         (sel),
        .blink_phase (blink_phase),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit blink_on(input int ticks);
        return (ticks % (B_ON + B_OFF)) < B_ON;
    endfunction

    // One clock: predict the post-edge outputs, advance, compare.
    task automatic cyc();
        int p, slot, dig;
        logic [7:0] es;
        logic [5:0] esel;
        logic [3:0] nib;
        bit eph, eft, latch, on_old;
        if (rst) begin
            es = 8'hFF; esel = 6'h3F; eph = 1'b1; eft = 1'b0;
            n = 0; k = 0; sp = 1'b0; sh_bcd = 24'h000000; sh_dp = 6'h00; sh_dim = 0;
        end else begin
            p      = n % DIV;
            slot   = n / DIV;
            dig    = (slot == 0) ? 0 : (slot - 1) % 6;
            on_old = blink_on(k);
            if (slot == 0 || p < BLANK) begin
                es = 8'hFF; esel = 6'h3F;
            end else begin
                esel = 6'h3F ^ (6'h01 << dig);
                nib  = sh_bcd[dig*4 +: 4];
                es   = {~sh_dp[dig], ~glyph_hi[nib]};
                if (set_en && !on_old && !blink_sel[dig]) es = 8'hFF;
`ifdef SEG_DIM_EN
                if (((p - BLANK) * 8) / (DIV - BLANK) > sh_dim) es = 8'hFF;
`endif
            end
            latch = (p == DIV - 1) && (slot == 0 || dig == 5);
            eft   = latch;
            if (latch) begin
                sh_bcd = bcd_in;
                sh_dp  = dp_in;
`ifdef SEG_DIM_EN
                sh_dim = int'(dim_level);
`endif
            end
            if (!set_en || !sp) k = 0;
            else if (p == DIV - 1) k = k + 1;
            sp  = set_en;
            eph = blink_on(k);
            n   = n + 1;
        end
        @(posedge clk);
        #1;
        chk("seg", seg, es);
        chk("sel", sel, esel);
        chk("blink_phase", blink_phase, eph);
        chk("frame_tick", frame_tick, eft);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    initial begin
        bit found;
        glyph_hi[0] = 7'h3F; glyph_hi[1] = 7'h06; glyph_hi[2]  = 7'h5B; glyph_hi[3]  = 7'h4F;
        glyph_hi[4] = 7'h66; glyph_hi[5] = 7'h6D; glyph_hi[6]  = 7'h7D; glyph_hi[7]  = 7'h07;
        glyph_hi[8] = 7'h7F; glyph_hi[9] = 7'h6F; glyph_hi[10] = 7'h00; glyph_hi[11] = 7'h00;
        glyph_hi[12] = 7'h00; glyph_hi[13] = 7'h00; glyph_hi[14] = 7'h00; glyph_hi[15] = 7'h40;

        // reset state
        run(3);
        chk("reset_seg", seg, 24'hFF);
        chk("reset_sel", sel, 24'h3F);
        chk("reset_phase", blink_phase, 24'h1);

        // 1: basic scan
        bcd_in = 24'h123456;
        rst = 1'b0;
        run(10);
        chk("frame_tick_clk11", frame_tick, 24'h1);
        run(3);
        chk("digit0_glyph6", seg, 24'h82);
        chk("digit0_sel", sel, 24'h3E);
        run(50);

        // 2: mid-frame change held until next wrap
        bcd_in = 24'h987654;
        dp_in  = 6'h15;
        run(80);

        // 3: blinking on digit 0
        set_en = 1'b1;
        blink_sel = 6'b111110;
        run(200);

        // 4: drop set_en during OFF, then re-raise
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!blink_on(k)) found = 1'b1;
            else cyc();
        end
        chk("off_phase_reached", {23'd0, found}, 24'h1);
        set_en = 1'b0;
        cyc();
        chk("phase_forced_on", blink_phase, 24'h1);
        run(15);
        set_en = 1'b1;
        run(150);

        // 5: dash / blank nibbles and mid-slot reset
        set_en = 1'b0;
        bcd_in = 24'h00AF00;
        dp_in  = 6'h00;
        run(130);
        while ((n % DIV) != 5) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_mid_seg", seg, 24'hFF);
        chk("rst_mid_sel", sel, 24'h3F);
        rst = 1'b0;
        run(40);

`ifdef SEG_DIM_EN
        // 6: dimming
        dim_level = 3'd1;
        run(130);
        dim_level = 3'd7;
`endif

        // randomized phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(19, 0) == 0) bcd_in = 24'($urandom);
            if ($urandom_range(29, 0) == 0) dp_in = 6'($urandom);
            if ($urandom_range(14, 0) == 0) blink_sel = 6'($urandom);
            if ($urandom_range(149, 0) == 0) set_en = ~set_en;
`ifdef SEG_DIM_EN
            if ($urandom_range(99, 0) == 0) dim_level = 3'($urandom);
`endif
            rst = ($urandom_range(999, 0) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
